microsequencer: RTL

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer_if.sv | 27 ++
 rtl/microsequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/microsequencer_if.sv
// Microsequencer bus: control-register fields in, microstore address and strobes out.
interface microsequencer_if #(
    parameter int unsigned AW = 8
);
    logic [2:0]    ns;
    logic          sts;
    logic          inv;
    logic [AW-1:0] pipe_addr;
    logic [AW-1:0] enc_addr;
    logic          wait_mfc;
    logic          mfc;
    logic [AW-1:0] uaddr;
    logic [1:0]    m;
    logic          cr_ld;
    logic          stall;
    logic          tmo_err;

    modport master (
        output ns, sts, inv, pipe_addr, enc_addr, wait_mfc, mfc,
        input  uaddr, m, cr_ld, stall, tmo_err
    );

    modport slave (
        input  ns, sts, inv, pipe_addr, enc_addr, wait_mfc, mfc,
        output uaddr, m, cr_ld, stall, tmo_err
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next microaddress, stalls on memory waits and
// diverts to a fault handler when memory completion never arrives.
module microsequencer #(
    parameter int unsigned   AW         = 8,
    parameter logic [AW-1:0] RESET_ADDR = '0,
    parameter logic [AW-1:0] FAULT_ADDR = AW'(8'hFF),
    parameter int unsigned   TMO        = 15
) (
    input logic            clk,
    input logic            reset_n,
    microsequencer_if.slave bus
);

    typedef enum logic [1:0] {StInit, StRun, StWait} state_e;

    // Last WAIT cycle count before the fault branch is taken.
    localparam logic [7:0] TmoLast = 8'(TMO - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] uaddr_q, uaddr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          s;
    logic [1:0]    m;
    logic [AW-1:0] cand;
    logic          cr_ld;
    logic          stall;

    assign s = bus.sts ^ bus.inv;

    // Next-address mux select decoded from the ns field and effective status.
    always_comb begin
        m = 2'b00;
        case (bus.ns)
            3'b000:  m = 2'b00;
            3'b001:  m = 2'b01;
            3'b010:  m = 2'b10;
            3'b011:  m = 2'b11;
            3'b100:  m = s ? 2'b10 : 2'b00;
            3'b101:  m = s ? 2'b10 : 2'b11;
            3'b110:  m = s ? 2'b00 : 2'b11;
            default: m = 2'b01;
        endcase
    end

    // Candidate next microaddress for the selected source.
    always_comb begin
        cand = uaddr_q;
        case (m)
            2'b00:   cand = bus.enc_addr;
            2'b01:   cand = RESET_ADDR;
            2'b10:   cand = bus.pipe_addr;
            default: cand = uaddr_q + AW'(1);
        endcase
    end

    // Sequencing FSM: next state, address, wait counter, strobes.
    always_comb begin
        state_d = state_q;
        uaddr_d = uaddr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        cr_ld   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            StInit: begin
                cr_ld   = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (bus.wait_mfc && !bus.mfc) begin
                    stall   = 1'b1;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    uaddr_d = cand;
                    cr_ld   = 1'b1;
                end
            end
            StWait: begin
                // Completion takes priority over a coincident timeout.
                if (bus.mfc) begin
                    uaddr_d = cand;
                    cr_ld   = 1'b1;
                    state_d = StRun;
                end else if (cnt_q == TmoLast) begin
                    uaddr_d = FAULT_ADDR;
                    tmo_d   = 1'b1;
                    cr_ld   = 1'b1;
                    stall   = 1'b1;
                    state_d = StRun;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            uaddr_q <= RESET_ADDR;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Strobes are forced low while reset is held, even though the FSM sits in INIT.
    assign bus.cr_ld   = cr_ld & reset_n;
    assign bus.stall   = stall & reset_n;
    assign bus.m       = m;
    assign bus.uaddr   = uaddr_q;
    assign bus.tmo_err = tmo_q;

endmodule
